// File: rtl/filter_sched.sv
// Frame-synchronous filter-mode scheduler: queues keypad mode requests and commits them at frame start.
// Optional auto-cycle (dwell timer + code-8 toggle) is built only when FILTER_SCHED_AUTO_EN is defined.
module filter_sched #(
    parameter int NUM_MODES = 6,
    parameter int EDGE_MODE = 5,
    parameter int AUTO_MS   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pls_1k,
    input  logic       i_key_valid,
    input  logic [4:0] i_bcd_data,
    input  logic       i_frame_start,
    output logic [2:0] o_mode,
    output logic       o_mode_chg,
    output logic       o_pending,
    output logic       o_auto,
    output logic       o_edgeon,
    output logic [3:0] o_disp
);

    // state = {auto, pending}; the outputs o_auto/o_pending are the state bits themselves
    localparam logic [1:0] MANUAL_IDLE = 2'b00;
    localparam logic [1:0] MANUAL_PEND = 2'b01;
    localparam logic [1:0] AUTO_IDLE   = 2'b10;
    localparam logic [1:0] AUTO_PEND   = 2'b11;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] req_mode;
    logic [2:0] req_nxt;
    logic [2:0] mode_nxt;
    logic [2:0] auto_req;
    logic       key_sel;
    logic       key_tog;
    logic       expire;
    logic       commit;
    logic       pend_nxt;
    logic       auto_nxt;

    assign key_sel   = i_key_valid && (i_bcd_data < 5'(NUM_MODES));
    assign o_pending = state[0];
    assign o_auto    = state[1];

`ifdef FILTER_SCHED_AUTO_EN
    logic [15:0] cnt;
    logic        cnt_hit;

    assign key_tog  = i_key_valid && (i_bcd_data == 5'd8);
    assign cnt_hit  = state[1] && i_pls_1k && (cnt == 16'(AUTO_MS - 1));
    // a manual key or a toggle in the expiry cycle takes precedence over the timer
    assign expire   = cnt_hit && !key_sel && !key_tog;
    assign auto_req = (o_mode == 3'(NUM_MODES - 1)) ? 3'd0 : o_mode + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (key_tog && !state[1]) begin
            cnt <= '0;
        end else if (state[1] && i_pls_1k) begin
            cnt <= cnt_hit ? 16'd0 : cnt + 16'd1;
        end
    end
`else
    logic unused_pls;

    assign unused_pls = i_pls_1k;
    assign key_tog    = 1'b0;
    assign expire     = 1'b0;
    assign auto_req   = 3'd0;
`endif

    always_comb begin
        req_nxt  = req_mode;
        pend_nxt = state[0];
        auto_nxt = state[1];
        if (key_sel) begin
            req_nxt  = i_bcd_data[2:0];
            pend_nxt = 1'b1;
            auto_nxt = 1'b0;
        end else begin
            if (key_tog) begin
                auto_nxt = !state[1];
            end
            if (expire) begin
                req_nxt  = auto_req;
                pend_nxt = 1'b1;
            end
        end
        // the newest request of this cycle is the one committed at a coincident frame start
        commit   = i_frame_start && pend_nxt;
        mode_nxt = commit ? req_nxt : o_mode;
        if (commit) begin
            pend_nxt = 1'b0;
        end
        case ({auto_nxt, pend_nxt})
            2'b00:   state_nxt = MANUAL_IDLE;
            2'b01:   state_nxt = MANUAL_PEND;
            2'b10:   state_nxt = AUTO_IDLE;
            default: state_nxt = AUTO_PEND;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MANUAL_IDLE;
            req_mode   <= '0;
            o_mode     <= '0;
            o_mode_chg <= 1'b0;
            o_edgeon   <= (EDGE_MODE == 0);
            o_disp     <= '0;
        end else begin
            state      <= state_nxt;
            req_mode   <= req_nxt;
            o_mode     <= mode_nxt;
            o_mode_chg <= commit && (req_nxt != o_mode);
            o_edgeon   <= (mode_nxt == 3'(EDGE_MODE));
            o_disp     <= {1'b0, state_nxt[0] ? req_nxt : mode_nxt};
        end
    end

endmodule
